// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity modes
// and the data-bit clamp used when a frame format is latched.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BREAK    = 3'd5,
        ST_BRK_STOP = 3'd6
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Frames carry at least 5 data bits and never more than the word width.
    function automatic logic [3:0] clamp_nbits(input logic [3:0] n,
                                               input logic [3:0] max_bits);
        if (n < 4'd5) begin
            return 4'd5;
        end else if (n > max_bits) begin
            return max_bits;
        end else begin
            return n;
        end
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous W x DEPTH FIFO with a combinational head word; shared by the
// TX path and reusable on the RX side. DEPTH must be a power of two.
module uart_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ext.sv
// UART transmitter with TX FIFO and runtime frame format (5..DATA_W bits,
// none/even/odd parity, 1/2 stops). Line break support under UART_TX_BREAK_EN.
// Handshake: a word is accepted on every rising edge where s_valid_i and
// s_ready_o are both high; s_ready_o depends only on the registered FIFO count.
module uart_tx_ext
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 29
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          locked_i,
    input  logic [CNT_W-1:0]              bitperiod_i,
    input  logic [3:0]                    cfg_nbits_i,
    input  logic [1:0]                    cfg_parity_i,
    input  logic                          cfg_stop2_i,
    input  logic                          s_valid_i,
    input  logic [DATA_W-1:0]             s_data_bi,
    output logic                          s_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          busy_o,
    output logic                          tx_done_tick_o,
`ifdef UART_TX_BREAK_EN
    input  logic                          break_i,
`endif
    output logic                          tx_o,
    output logic [2:0]                    dbg_state_o
);

    localparam logic [3:0] MAX_BITS = 4'(DATA_W);

    tx_state_e           state_q;
    tx_state_e           state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    bp_q;
    logic [3:0]          nbits_q;
    logic [1:0]          par_mode_q;
    logic                stop2_q;
    logic                stop_idx_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [3:0]          bit_q;
    logic                par_q;
    logic                avail_q;

    logic                fifo_push;
    logic                fifo_pop;
    logic [DATA_W-1:0]   fifo_head;
    logic                fifo_full;
    logic                fifo_empty;

    logic [3:0]          nbits_in;
    logic [DATA_W-1:0]   in_mask;
    logic [DATA_W-1:0]   head_masked;
    logic                tc;
    logic                last_bit;
    logic                last_stop;
    logic                par_en;
    logic                cnt_clr;
    logic                brk;

`ifdef UART_TX_BREAK_EN
    assign brk = break_i;
`else
    assign brk = 1'b0;
`endif

    uart_tx_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (s_data_bi),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .count_o (fifo_count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign s_ready_o   = !fifo_full;
    assign fifo_push   = s_valid_i && s_ready_o;
    assign dbg_state_o = state_q;

    assign nbits_in = clamp_nbits(cfg_nbits_i, MAX_BITS);

    always_comb begin
        in_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            in_mask[i] = (4'(i) < nbits_in);
        end
    end

    assign head_masked = fifo_head & in_mask;
    assign tc          = (cnt_q == bp_q);
    assign last_bit    = (bit_q == nbits_q - 4'd1);
    assign last_stop   = !stop2_q || stop_idx_q;
    assign par_en      = (par_mode_q == PAR_EVEN) || (par_mode_q == PAR_ODD);
    assign cnt_clr     = tc || (state_d != state_q) ||
                         (state_q == ST_IDLE) || (state_q == ST_BREAK);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new word waits one extra cycle in the FIFO before a frame may start;
    // back-to-back frames are unaffected because avail_q is already set.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (brk) begin
                    state_d = ST_BREAK;
                end else if (avail_q && !fifo_empty && locked_i) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (tc) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tc && last_bit) state_d = par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (tc) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tc && last_stop) state_d = ST_IDLE;
            end
            ST_BREAK: begin
                if (!brk) state_d = ST_BRK_STOP;
            end
            ST_BRK_STOP: begin
                if (tc) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_o           = 1'b1;
        busy_o         = 1'b1;
        tx_done_tick_o = 1'b0;
        case (state_q)
            ST_IDLE:   busy_o = 1'b0;
            ST_BREAK: begin
                tx_o   = 1'b0;
                busy_o = 1'b0;
            end
            ST_START:  tx_o = 1'b0;
            ST_DATA:   tx_o = shreg_q[0];
            ST_PARITY: tx_o = par_q ^ (par_mode_q == PAR_ODD);
            ST_STOP:   tx_done_tick_o = tc && last_stop;
            default: begin
                tx_o   = 1'b1;
                busy_o = 1'b1;
            end
        endcase
    end

    // Frame format and data are captured at pop so later config writes
    // cannot disturb a frame in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            bp_q       <= '0;
            nbits_q    <= 4'd5;
            par_mode_q <= PAR_NONE;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            bit_q      <= '0;
            par_q      <= 1'b0;
            avail_q    <= 1'b0;
        end else begin
            avail_q <= !fifo_empty;
            cnt_q   <= cnt_clr ? '0 : cnt_q + CNT_W'(1);
            if (fifo_pop) begin
                bp_q       <= bitperiod_i;
                nbits_q    <= nbits_in;
                par_mode_q <= cfg_parity_i;
                stop2_q    <= cfg_stop2_i;
                stop_idx_q <= 1'b0;
                shreg_q    <= head_masked;
                bit_q      <= '0;
                par_q      <= ^head_masked;
            end
            if (state_q == ST_BREAK) begin
                bp_q <= bitperiod_i;
            end
            if (state_q == ST_DATA && tc) begin
                shreg_q <= shreg_q >> 1;
                bit_q   <= bit_q + 4'd1;
            end
            if (state_q == ST_STOP && tc) begin
                stop_idx_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ext.sv
// Self-checking bench for uart_tx_ext: directed frame formats, FIFO full and
// back-to-back behaviour, clock-lock gating, reset abort and random frames.
module tb_uart_tx_ext;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 29;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              locked = 1'b0;
    logic [CNT_W-1:0]  bitperiod = '0;
    logic [3:0]        cfg_nbits = 4'd8;
    logic [1:0]        cfg_parity = 2'b00;
    logic              cfg_stop2 = 1'b0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_ready_o;
    logic [CW-1:0]     fifo_count_o;
    logic              busy_o;
    logic              tx_done_tick_o;
    logic              tx_o;
    logic [2:0]        dbg_state_o;
`ifdef UART_TX_BREAK_EN
    logic              break_i = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_ext #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .locked_i       (locked),
        .bitperiod_i    (bitperiod),
        .cfg_nbits_i    (cfg_nbits),
        .cfg_parity_i   (cfg_parity),
        .cfg_stop2_i    (cfg_stop2),
        .s_valid_i      (s_valid),
        .s_data_bi      (s_data),
        .s_ready_o      (s_ready_o),
        .fifo_count_o   (fifo_count_o),
        .busy_o         (busy_o),
        .tx_done_tick_o (tx_done_tick_o),
`ifdef UART_TX_BREAK_EN
        .break_i        (break_i),
`endif
        .tx_o           (tx_o),
        .dbg_state_o    (dbg_state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_cfg(input int bp, input int nb, input int par, input int st2);
        bitperiod  = CNT_W'(bp);
        cfg_nbits  = 4'(nb);
        cfg_parity = 2'(par);
        cfg_stop2  = (st2 != 0);
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        int guard = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        while (s_ready_o !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Reference frame: start, nb data bits LSB first, optional parity, stops.
    // Waits for the start bit, then checks tx/busy/done on every cycle.
    task automatic check_frame(input string name, input logic [DATA_W-1:0] word,
                               input int nb_raw, input int par, input int stop2,
                               input int bp, output int waits);
        logic exp_q[$];
        int   nb;
        int   total;
        logic p;
        bit   bad_tx, bad_busy, bad_done;
        logic exp_done;
        exp_q.delete();
        nb = (nb_raw < 5) ? 5 : ((nb_raw > DATA_W) ? DATA_W : nb_raw);
        p = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back(word[i]);
            p = p ^ word[i];
        end
        if (par == 1) exp_q.push_back(p);
        else if (par == 2) exp_q.push_back(~p);
        exp_q.push_back(1'b1);
        if (stop2 != 0) exp_q.push_back(1'b1);

        waits = 0;
        while (tx_o !== 1'b0 && waits < 400) begin
            @(negedge clk);
            waits++;
        end
        n_cmp++;
        if (tx_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s start: tx_o=%b after %0d cycles, required 0", name, tx_o, waits);
            return;
        end
        bad_tx = 0; bad_busy = 0; bad_done = 0;
        total = exp_q.size() * (bp + 1);
        for (int k = 0; k < total; k++) begin
            if (k > 0) @(negedge clk);
            exp_done = (k == total - 1);
            if (tx_o !== exp_q[k / (bp + 1)] && !bad_tx) begin
                bad_tx = 1;
                $display("FAIL %s tx: cycle %0d got %b required %b", name, k, tx_o, exp_q[k / (bp + 1)]);
            end
            if (busy_o !== 1'b1 && !bad_busy) begin
                bad_busy = 1;
                $display("FAIL %s busy: cycle %0d got %b required 1", name, k, busy_o);
            end
            if (tx_done_tick_o !== exp_done && !bad_done) begin
                bad_done = 1;
                $display("FAIL %s done: cycle %0d got %b required %b", name, k, tx_done_tick_o, exp_done);
            end
        end
        n_cmp += 3;
        n_err += int'(bad_tx) + int'(bad_busy) + int'(bad_done);
        @(negedge clk);
        n_cmp++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || tx_done_tick_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle: tx=%b busy=%b done=%b required 1/0/0", name, tx_o, busy_o, tx_done_tick_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx_o !== 1'b1) begin n_err++; $display("FAIL reset tx: got %b required 1", tx_o); end
        n_cmp++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b required 0", busy_o); end
        n_cmp++;
        if (tx_done_tick_o !== 1'b0) begin n_err++; $display("FAIL reset done: got %b required 0", tx_done_tick_o); end
        n_cmp++;
        if (fifo_count_o !== '0) begin n_err++; $display("FAIL reset count: got %0d required 0", fifo_count_o); end
        n_cmp++;
        if (s_ready_o !== 1'b1) begin n_err++; $display("FAIL reset ready: got %b required 1", s_ready_o); end
        rst = 1'b0;
    endtask

    task automatic test_formats();
        int wt;
        locked = 1'b1;
        set_cfg(3, 8, 0, 0);
        push_word(8'hA5);
        check_frame("a5_8n1", 8'hA5, 8, 0, 0, 3, wt);
        n_cmp++;
        if (wt !== 2) begin n_err++; $display("FAIL latency_8n1: got %0d cycles required 2", wt); end

        set_cfg(3, 8, 2, 1);
        push_word(8'hA5);
        check_frame("a5_8o2", 8'hA5, 8, 2, 1, 3, wt);
        n_cmp++;
        if (wt !== 2) begin n_err++; $display("FAIL latency_8o2: got %0d cycles required 2", wt); end

        set_cfg(3, 8, 1, 0);
        push_word(8'hA5);
        check_frame("a5_8e1", 8'hA5, 8, 1, 0, 3, wt);

        set_cfg(2, 5, 1, 0);
        push_word(8'hFF);
        check_frame("ff_5e1", 8'hFF, 5, 1, 0, 2, wt);

        set_cfg(1, 2, 3, 1);
        push_word(8'h3C);
        check_frame("clamp_lo", 8'h3C, 2, 3, 1, 1, wt);

        set_cfg(0, 15, 2, 0);
        push_word(8'h81);
        check_frame("clamp_hi_bp0", 8'h81, 15, 2, 0, 0, wt);
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] words[5];
        logic [DATA_W-1:0] sb_q[$];
        int   idx = 0;
        int   guard = 0;
        int   wt;
        logic rdy;
        set_cfg(1, 8, 0, 0);
        locked = 1'b0;
        for (int i = 0; i < 5; i++) begin
            words[i] = DATA_W'($urandom_range(0, 255));
            sb_q.push_back(words[i]);
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = words[0];
        while (idx < 4 && guard < 50) begin
            rdy = s_ready_o;
            @(negedge clk);
            guard++;
            if (rdy) begin
                idx++;
                s_data = words[idx];
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (s_ready_o !== 1'b0 || fifo_count_o !== CW'(4)) begin
            n_err++;
            $display("FAIL fifo_full: ready=%b count=%0d required 0/4", s_ready_o, fifo_count_o);
        end
        locked = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (s_ready_o !== 1'b1 || fifo_count_o !== CW'(3)) begin
            n_err++;
            $display("FAIL ready_after_pop: ready=%b count=%0d required 1/3", s_ready_o, fifo_count_o);
        end
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    check_frame("b2b", sb_q.pop_front(), 8, 0, 0, 1, wt);
                    n_cmp++;
                    if (wt !== ((i == 0) ? 0 : 1)) begin
                        n_err++;
                        $display("FAIL b2b_gap: frame %0d waited %0d required %0d", i, wt, (i == 0) ? 0 : 1);
                    end
                end
            end
            begin
                @(negedge clk);
                s_valid = 1'b0;
            end
        join
    endtask

    task automatic test_locked();
        logic [DATA_W-1:0] w0, w1;
        int   wt;
        bit   saw_low;
        w0 = DATA_W'($urandom_range(0, 255));
        w1 = DATA_W'($urandom_range(0, 255));
        set_cfg(2, 8, 0, 0);
        locked = 1'b0;
        push_word(w0);
        push_word(w1);
        saw_low = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_o !== 1'b1) saw_low = 1;
        end
        n_cmp++;
        if (saw_low || fifo_count_o !== CW'(2)) begin
            n_err++;
            $display("FAIL locked_hold: tx_low_seen=%b count=%0d required 0/2", saw_low, fifo_count_o);
        end
        locked = 1'b1;
        fork
            check_frame("locked_w0", w0, 8, 0, 0, 2, wt);
            begin
                repeat (10) @(negedge clk);
                locked = 1'b0;
            end
        join
        n_cmp++;
        if (wt !== 1) begin n_err++; $display("FAIL locked_start: waited %0d required 1", wt); end
        saw_low = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_o !== 1'b1) saw_low = 1;
        end
        n_cmp++;
        if (saw_low || fifo_count_o !== CW'(1)) begin
            n_err++;
            $display("FAIL unlock_midframe: tx_low_seen=%b count=%0d required 0/1", saw_low, fifo_count_o);
        end
        locked = 1'b1;
        check_frame("locked_w1", w1, 8, 0, 0, 2, wt);
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        bit saw_low;
        set_cfg(3, 8, 0, 0);
        locked = 1'b1;
        push_word(8'h5A);
        push_word(8'hC3);
        while (tx_o !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_line: tx=%b busy=%b required 1/0", tx_o, busy_o);
        end
        n_cmp++;
        if (fifo_count_o !== '0 || s_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_fifo: count=%0d ready=%b required 0/1", fifo_count_o, s_ready_o);
        end
        rst = 1'b0;
        saw_low = 0;
        repeat (12) begin
            @(negedge clk);
            if (tx_o !== 1'b1) saw_low = 1;
        end
        n_cmp++;
        if (saw_low) begin n_err++; $display("FAIL reset_mid_quiet: tx went low, required 1"); end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] w;
        int bp, nb, par, st2, wt;
        locked = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w   = DATA_W'($urandom_range(0, 255));
            bp  = $urandom_range(0, 4);
            nb  = $urandom_range(0, 15);
            par = $urandom_range(0, 3);
            st2 = $urandom_range(0, 1);
            set_cfg(bp, nb, par, st2);
            push_word(w);
            fork
                check_frame("random", w, nb, par, st2, bp, wt);
                begin
                    repeat (4) @(negedge clk);
                    set_cfg($urandom_range(0, 6), $urandom_range(0, 15),
                            $urandom_range(0, 3), $urandom_range(0, 1));
                end
            join
            n_cmp++;
            if (wt !== 2) begin n_err++; $display("FAIL random_latency: frame %0d waited %0d required 2", i, wt); end
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_locked();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
